// File: rtl/mips_pkg.sv
// Shared types for the pipeline hazard unit: MDU sequencer states and the
// forward-select encodings driven onto the E-stage operand muxes.
package mips_pkg;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b10;
    localparam logic [1:0] FWD_W  = 2'b01;

    // M-stage data is younger than W-stage data, so it takes priority.
    function automatic logic [1:0] fwd_select(input logic hit_m, input logic hit_w);
        logic [1:0] sel;
        sel = FWD_RF;
        if (hit_m) begin
            sel = FWD_M;
        end else if (hit_w) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

endpackage

// File: rtl/mdu_scoreboard.sv
// Multi-cycle unit tracker: latency down-counter, IDLE/BUSY sequencer and the
// per-register pending vector used by the hazard unit.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   MDU_IDLE | no op in flight, or the op is in its result (mdudone) cycle
//   MDU_BUSY | op in flight, counter counts down towards its result cycle
module mdu_scoreboard
    import mips_pkg::*;
#(
    parameter int REGW    = 5,
    parameter int MDU_LAT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mdustartE,
    input  logic [REGW-1:0]      mdudstE,
    output logic [2**REGW-1:0]   pending,
    output logic                 mdubusy,
    output logic                 mdudone,
    output logic [REGW-1:0]      mdudst
);

    localparam logic [3:0] CNT_LOAD = 4'(MDU_LAT - 1);

    mdu_state_t          state;
    logic [3:0]          count;
    logic                start_accept;
    logic [2**REGW-1:0]  pending_next;

    // The result cycle runs in IDLE, so a start there is accepted back-to-back;
    // a start during BUSY is a structural hazard and is dropped.
    assign start_accept = mdustartE && (state == MDU_IDLE);
    assign mdubusy      = (state == MDU_BUSY);

    // Sequencer: load on accepted start, count down while busy, pulse done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= MDU_IDLE;
            count   <= 4'd0;
            mdudone <= 1'b0;
            mdudst  <= '0;
        end else begin
            mdudone <= 1'b0;
            case (state)
                MDU_IDLE: begin
                    if (start_accept) begin
                        state  <= MDU_BUSY;
                        count  <= CNT_LOAD;
                        mdudst <= mdudstE;
                    end
                end
                MDU_BUSY: begin
                    count <= count - 4'd1;
                    if (count == 4'd1) begin
                        state   <= MDU_IDLE;
                        mdudone <= 1'b1;
                    end
                end
                default: begin
                    state <= MDU_IDLE;
                    count <= 4'd0;
                end
            endcase
        end
    end

    // Next pending vector: retire the finishing op, then a new start sets its
    // bit so a same-destination back-to-back start keeps the register pending.
    always_comb begin
        pending_next = pending;
        if (mdudone) begin
            pending_next[mdudst] = 1'b0;
        end
        if (start_accept) begin
            pending_next[mdudstE] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    // Pending vector register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: operand forwarding selects plus the combined
// stall/flush request from load-use, branch, MDU structural and scoreboard
// RAW/WAW hazards.
module hazard_scoreboard
    import mips_pkg::*;
#(
    parameter int REGW    = 5,
    parameter int MDU_LAT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REGW-1:0]   rsD,
    input  logic [REGW-1:0]   rtD,
    input  logic [REGW-1:0]   rsE,
    input  logic [REGW-1:0]   rtE,
    input  logic [REGW-1:0]   writeregD,
    input  logic [REGW-1:0]   writeregE,
    input  logic [REGW-1:0]   writeregM,
    input  logic [REGW-1:0]   writeregW,
    input  logic              regwriteD,
    input  logic              regwriteE,
    input  logic              regwriteM,
    input  logic              regwriteW,
    input  logic              memtoregE,
    input  logic              memtoregM,
    input  logic              branchD,
    input  logic              mdustartE,
    input  logic [REGW-1:0]   mdudstE,
    output logic              forwardaD,
    output logic              forwardbD,
    output logic [1:0]        forwardaE,
    output logic [1:0]        forwardbE,
    output logic              stallF,
    output logic              stallD,
    output logic              flushE,
    output logic              mdubusy,
    output logic              mdudone,
    output logic [REGW-1:0]   mdudst
);

    logic [2**REGW-1:0] pending;
    logic               load_use;
    logic               branch_e;
    logic               branch_m;
    logic               sb_raw;
    logic               sb_waw;
    logic               structural;
    logic               stall;

    mdu_scoreboard #(
        .REGW    (REGW),
        .MDU_LAT (MDU_LAT)
    ) u_mdu (
        .clk       (clk),
        .reset     (reset),
        .mdustartE (mdustartE),
        .mdudstE   (mdudstE),
        .pending   (pending),
        .mdubusy   (mdubusy),
        .mdudone   (mdudone),
        .mdudst    (mdudst)
    );

    // Forwarding selects; register 0 is hardwired and never forwarded.
    always_comb begin
        forwardaE = fwd_select((rsE != '0) && regwriteM && (rsE == writeregM),
                               (rsE != '0) && regwriteW && (rsE == writeregW));
        forwardbE = fwd_select((rtE != '0) && regwriteM && (rtE == writeregM),
                               (rtE != '0) && regwriteW && (rtE == writeregW));
        forwardaD = (rsD != '0) && regwriteM && (rsD == writeregM);
        forwardbD = (rtD != '0) && regwriteM && (rtD == writeregM);
    end

    // Hazard terms; pending[0] is never set so scoreboard terms ignore r0.
    always_comb begin
        load_use   = memtoregE && (rtE != '0) && ((rsD == rtE) || (rtD == rtE));
        branch_e   = branchD && regwriteE && (writeregE != '0) &&
                     ((writeregE == rsD) || (writeregE == rtD));
        branch_m   = branchD && memtoregM && (writeregM != '0) &&
                     ((writeregM == rsD) || (writeregM == rtD));
        sb_raw     = pending[rsD] || pending[rtD];
        sb_waw     = regwriteD && pending[writeregD];
        structural = mdustartE && mdubusy;
        stall      = load_use || branch_e || branch_m || sb_raw || sb_waw || structural;
    end

    assign stallF = stall;
    assign stallD = stall;
    assign flushE = stall;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed bench for hazard_scoreboard with an op-level model
// of the multi-cycle unit (start time, destination, latency).
module tb_hazard_scoreboard;

    localparam int REGW = 5;
    localparam int LAT  = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [REGW-1:0] rsD, rtD, rsE, rtE, writeregD, writeregE, writeregM, writeregW;
    logic            regwriteD, regwriteE, regwriteM, regwriteW;
    logic            memtoregE, memtoregM, branchD, mdustartE;
    logic [REGW-1:0] mdudstE;
    logic            forwardaD, forwardbD, stallF, stallD, flushE, mdubusy, mdudone;
    logic [1:0]      forwardaE, forwardbE;
    logic [REGW-1:0] mdudst;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    // op-level model of the multi-cycle unit
    logic            op_active = 1'b0;
    logic [REGW-1:0] op_dst = '0;
    logic [REGW-1:0] mdudst_m = '0;
    int              edge_cnt = 0;
    int              start_edge = 0;

    hazard_scoreboard #(.REGW(REGW), .MDU_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregD(writeregD), .writeregE(writeregE),
        .writeregM(writeregM), .writeregW(writeregW),
        .regwriteD(regwriteD), .regwriteE(regwriteE),
        .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM), .branchD(branchD),
        .mdustartE(mdustartE), .mdudstE(mdudstE),
        .forwardaD(forwardaD), .forwardbD(forwardbD),
        .forwardaE(forwardaE), .forwardbE(forwardbE),
        .stallF(stallF), .stallD(stallD), .flushE(flushE),
        .mdubusy(mdubusy), .mdudone(mdudone), .mdudst(mdudst)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // cycle index of the in-flight op: 1 right after its start edge
    function automatic int op_cycle();
        return edge_cnt - start_edge + 1;
    endfunction

    function automatic logic m_busy();
        return op_active && (op_cycle() <= LAT - 1);
    endfunction

    function automatic logic m_done();
        return op_active && (op_cycle() == LAT);
    endfunction

    function automatic logic m_pend(input logic [REGW-1:0] r);
        return (r != 0) && op_active && (r == op_dst) && (op_cycle() <= LAT);
    endfunction

    function automatic logic [1:0] m_fwdE(input logic [REGW-1:0] s);
        if (s != 0 && regwriteM && s == writeregM) return 2'b10;
        if (s != 0 && regwriteW && s == writeregW) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic m_stall();
        logic st;
        st = mdustartE && m_busy();
        st = st || (memtoregE && rtE != 0 && (rsD == rtE || rtD == rtE));
        st = st || (branchD && regwriteE && writeregE != 0 &&
                    (writeregE == rsD || writeregE == rtD));
        st = st || (branchD && memtoregM && writeregM != 0 &&
                    (writeregM == rsD || writeregM == rtD));
        st = st || m_pend(rsD) || m_pend(rtD) || (regwriteD && m_pend(writeregD));
        return st;
    endfunction

    task automatic model_reset();
        op_active = 1'b0;
        mdudst_m  = '0;
    endtask

    task automatic model_step();
        if (!reset) begin
            model_reset();
        end else begin
            if (mdustartE && !m_busy()) begin
                op_active  = 1'b1;
                op_dst     = mdudstE;
                mdudst_m   = mdudstE;
                start_edge = edge_cnt + 1;
            end else if (m_done()) begin
                op_active = 1'b0;
            end
        end
        edge_cnt++;
    endtask

    task automatic step_edge();
        @(posedge clk);
        model_step();
    endtask

    task automatic idle_inputs();
        {rsD, rtD, rsE, rtE} = '0;
        {writeregD, writeregE, writeregM, writeregW} = '0;
        {regwriteD, regwriteE, regwriteM, regwriteW} = '0;
        {memtoregE, memtoregM, branchD, mdustartE} = '0;
        mdudstE = '0;
    endtask

    task automatic check_all();
        logic st;
        st = m_stall();
        cmp("stallF", stallF, st);
        cmp("stallD", stallD, st);
        cmp("flushE", flushE, st);
        cmp("forwardaE", forwardaE, m_fwdE(rsE));
        cmp("forwardbE", forwardbE, m_fwdE(rtE));
        cmp("forwardaD", forwardaD, rsD != 0 && regwriteM && rsD == writeregM);
        cmp("forwardbD", forwardbD, rtD != 0 && regwriteM && rtD == writeregM);
        cmp("mdubusy", mdubusy, m_busy());
        cmp("mdudone", mdudone, m_done());
        cmp("mdudst", mdudst, mdudst_m);
    endtask

    // Per-cycle comparison against the model, mid low phase.
    always @(negedge clk) begin
        #2;
        if (chk_en) check_all();
    end

    initial begin
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        cmp("rst_busy", mdubusy, 0);
        cmp("rst_done", mdudone, 0);
        cmp("rst_dst", mdudst, 0);
        @(negedge clk);
        reset  = 1'b1;
        chk_en = 1'b1;
        model_reset();
        #3;
        step_edge();

        // latency and RAW stall window for dst=5
        @(negedge clk); idle_inputs(); mdustartE = 1; mdudstE = 5; #3; step_edge();
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk); idle_inputs(); rsD = 5; #3;
            cmp("l030_stall", stallF, c <= 4);
            cmp("l030_done", mdudone, c == 4);
            if (c == 4) cmp("l030_dst", mdudst, 5);
            step_edge();
        end

        // back-to-back same destination
        @(negedge clk); idle_inputs(); mdustartE = 1; mdudstE = 3; #3; step_edge();
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk); idle_inputs(); rsD = 3;
            if (c == 4) begin mdustartE = 1; mdudstE = 3; end
            #3;
            cmp("l031_stall", stallD, c <= 8);
            cmp("l031_done", mdudone, c == 4 || c == 8);
            step_edge();
        end

        // structural hazard while busy
        @(negedge clk); idle_inputs(); mdustartE = 1; mdudstE = 6; #3; step_edge();
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk); idle_inputs(); rsD = 7;
            if (c == 2) begin mdustartE = 1; mdudstE = 7; end
            #3;
            cmp("l032_flush", flushE, c == 2);
            cmp("l032_done", mdudone, c == 4);
            if (c == 4) cmp("l032_dst", mdudst, 6);
            step_edge();
        end

        // load-use and forwarding, idle MDU
        @(negedge clk); idle_inputs(); memtoregE = 1; rtE = 7; rsD = 7; #3;
        cmp("l033_lu", stallF, 1);
        step_edge();
        @(negedge clk); idle_inputs(); memtoregE = 1; rtE = 0; rsD = 0; #3;
        cmp("l033_r0", stallF, 0);
        step_edge();
        @(negedge clk); idle_inputs();
        regwriteM = 1; writeregM = 9; regwriteW = 1; writeregW = 9; rsE = 9; rsD = 9; #3;
        cmp("l034_m", forwardaE, 2'b10);
        cmp("l034_d", forwardaD, 1);
        step_edge();
        @(negedge clk); idle_inputs();
        regwriteM = 0; writeregM = 9; regwriteW = 1; writeregW = 9; rsE = 9; #3;
        cmp("l034_w", forwardaE, 2'b01);
        step_edge();

        // reset mid-operation
        @(negedge clk); idle_inputs(); mdustartE = 1; mdudstE = 10; #3; step_edge();
        @(negedge clk); idle_inputs(); rsD = 10; #3;
        cmp("l035_pre", stallF, 1);
        step_edge();
        @(negedge clk); idle_inputs(); rsD = 10; #3;
        reset = 1'b0;
        model_reset();
        #1;
        cmp("l035_busy", mdubusy, 0);
        cmp("l035_done", mdudone, 0);
        cmp("l035_stall", stallF, 0);
        step_edge();
        @(negedge clk); reset = 1'b1; idle_inputs(); rsD = 10; #3; step_edge();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); idle_inputs(); rsD = 10; #3;
            cmp("l035_nodone", mdudone, 0);
            cmp("l035_nostall", stallF, 0);
            step_edge();
        end
        @(negedge clk); idle_inputs(); mdustartE = 1; mdudstE = 10; #3; step_edge();
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); idle_inputs(); #3;
            cmp("l035_redo", mdudone, c == 4);
            step_edge();
        end

        // randomized traffic with occasional mid-cycle resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!reset) reset = 1'b1;
            rsD       = REGW'($urandom_range(0, 7));
            rtD       = REGW'($urandom_range(0, 7));
            rsE       = REGW'($urandom_range(0, 7));
            rtE       = REGW'($urandom_range(0, 7));
            writeregD = REGW'($urandom_range(0, 7));
            writeregE = REGW'($urandom_range(0, 7));
            writeregM = REGW'($urandom_range(0, 7));
            writeregW = REGW'($urandom_range(0, 7));
            regwriteD = 1'($urandom_range(0, 1));
            regwriteE = 1'($urandom_range(0, 1));
            regwriteM = 1'($urandom_range(0, 1));
            regwriteW = 1'($urandom_range(0, 1));
            memtoregE = ($urandom_range(0, 3) == 0);
            memtoregM = ($urandom_range(0, 3) == 0);
            branchD   = ($urandom_range(0, 3) == 0);
            mdustartE = ($urandom_range(0, 2) == 0);
            mdudstE   = REGW'($urandom_range(0, 7));
            #3;
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b0;
                model_reset();
            end
            step_edge();
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
